// File: rtl/gray_ptr_fifo_ctrl.sv
// gray_ptr_fifo_ctrl: single-clock FIFO pointer controller with registered Gray pointers
module gray_ptr_fifo_ctrl #(
  parameter int depthLog2 = 3
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  input  logic                 Clr,
  input  logic                 PushReq,
  output logic                 PushAck,
  input  logic                 PopReq,
  output logic                 PopAck,
  output logic [depthLog2-1:0] WrAddr,
  output logic [depthLog2-1:0] RdAddr,
  output logic [depthLog2:0]   WrPtrG,
  output logic [depthLog2:0]   RdPtrG,
  output logic [depthLog2:0]   Count,
  output logic                 Full,
  output logic                 Empty,
  output logic                 OvfErr,
  output logic                 UdfErr
);
  localparam int W = depthLog2 + 1;
  logic [W-1:0] wr_bin, rd_bin, wr_nxt, rd_nxt;
  assign Count   = wr_bin - rd_bin;
  assign Empty   = wr_bin == rd_bin;
  assign Full    = (wr_bin[depthLog2] != rd_bin[depthLog2]) && (wr_bin[depthLog2-1:0] == rd_bin[depthLog2-1:0]);
  assign PushAck = PushReq & ~Full;
  assign PopAck  = PopReq & ~Empty;
  assign WrAddr  = wr_bin[depthLog2-1:0];
  assign RdAddr  = rd_bin[depthLog2-1:0];
  // next binary pointers; Gray copies are taken from these so they never lag
  always_comb begin
    wr_nxt = wr_bin + W'(PushAck);
    rd_nxt = rd_bin + W'(PopAck);
  end
  // pointer, Gray and sticky error registers; reset beats clear beats requests
  always_ff @(posedge CLK) begin
    if (!RSTn || Clr) begin
      wr_bin <= '0;
      rd_bin <= '0;
      WrPtrG <= '0;
      RdPtrG <= '0;
      OvfErr <= 1'b0;
      UdfErr <= 1'b0;
    end else begin
      wr_bin <= wr_nxt;
      rd_bin <= rd_nxt;
      WrPtrG <= wr_nxt ^ (wr_nxt >> 1);
      RdPtrG <= rd_nxt ^ (rd_nxt >> 1);
      OvfErr <= OvfErr | (PushReq & Full);
      UdfErr <= UdfErr | (PopReq & Empty);
    end
  end
endmodule

// File: tb/tb_gray_ptr_fifo_ctrl.sv
// tb_gray_ptr_fifo_ctrl: queue-model checker for gray_ptr_fifo_ctrl at depth 4
module tb_gray_ptr_fifo_ctrl;
  logic CLK = 1'b0;
  logic RSTn = 1'b0, Clr = 1'b0, PushReq = 1'b0, PopReq = 1'b0;
  logic PushAck, PopAck, Full, Empty, OvfErr, UdfErr;
  logic [1:0] WrAddr, RdAddr;
  logic [2:0] WrPtrG, RdPtrG, Count;
  int checks = 0, failures = 0;
  int q[$];
  int mem[4];
  int wr_tot = 0, rd_tot = 0, wdat = 100, sz;
  bit ovf = 0, udf = 0, mv = 0, lc = 1, wrap_seen = 0;
  logic [2:0] prev_w = '0, prev_r = '0;

  gray_ptr_fifo_ctrl #(.depthLog2(2)) dut (
    .CLK(CLK), .RSTn(RSTn), .Clr(Clr),
    .PushReq(PushReq), .PushAck(PushAck), .PopReq(PopReq), .PopAck(PopAck),
    .WrAddr(WrAddr), .RdAddr(RdAddr), .WrPtrG(WrPtrG), .RdPtrG(RdPtrG),
    .Count(Count), .Full(Full), .Empty(Empty), .OvfErr(OvfErr), .UdfErr(UdfErr)
  );

  always #5 CLK = ~CLK;

  function automatic int gray(input int x);
    return x ^ (x >> 1);
  endfunction

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", n, a, e, $time);
    end
  endtask

  task automatic cyc(input logic pu, input logic po, input logic cl, input logic rn);
    PushReq = pu;
    PopReq = po;
    Clr = cl;
    RSTn = rn;
    @(posedge CLK);
    #1;
  endtask

  always @(posedge CLK) begin
    if (!RSTn || Clr) begin
      q.delete();
      wr_tot = 0;
      rd_tot = 0;
      ovf = 0;
      udf = 0;
      mv = 1;
      lc = 1;
    end else begin
      sz = q.size();
      lc = 0;
      if (PushReq && sz < 4) begin
        mem[wr_tot % 4] = wdat;
        q.push_back(wdat);
        wdat++;
        wr_tot++;
      end
      if (PopReq && sz > 0) begin
        void'(q.pop_front());
        rd_tot++;
      end
      if (PushReq && sz == 4) ovf = 1;
      if (PopReq && sz == 0) udf = 1;
    end
  end

  always @(negedge CLK) begin
    if (mv) begin
      chk("count", Count, q.size());
      chk("full", Full, q.size() == 4);
      chk("empty", Empty, q.size() == 0);
      chk("wraddr", WrAddr, wr_tot % 4);
      chk("rdaddr", RdAddr, rd_tot % 4);
      chk("wrptrg", WrPtrG, gray(wr_tot % 8));
      chk("rdptrg", RdPtrG, gray(rd_tot % 8));
      chk("ovferr", OvfErr, ovf);
      chk("udferr", UdfErr, udf);
      chk("pushack", PushAck, PushReq && q.size() < 4);
      chk("popack", PopAck, PopReq && q.size() > 0);
      if (q.size() > 0) chk("rddata", mem[RdAddr], q[0]);
      if (!lc && WrPtrG !== prev_w) chk("wr_hamming", $countones(WrPtrG ^ prev_w), 1);
      if (!lc && RdPtrG !== prev_r) chk("rd_hamming", $countones(RdPtrG ^ prev_r), 1);
      if (!lc && prev_w == 3'b100 && WrPtrG == 3'b000) wrap_seen = 1;
      prev_w = WrPtrG;
      prev_r = RdPtrG;
    end
  end

  initial begin
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 1);
    chk("rst_empty", Empty, 1);
    chk("rst_full", Full, 0);
    chk("rst_count", Count, 0);
    chk("rst_wrptrg", WrPtrG, 0);
    chk("rst_rdptrg", RdPtrG, 0);
    chk("rst_wraddr", WrAddr, 0);
    chk("rst_rdaddr", RdAddr, 0);
    begin
      logic [2:0] gseq [4];
      gseq = '{3'b001, 3'b011, 3'b010, 3'b110};
      for (int i = 0; i < 4; i++) begin
        chk("push_wraddr", WrAddr, i);
        cyc(1, 0, 0, 1);
        chk("push_wrptrg", WrPtrG, gseq[i]);
      end
    end
    chk("full_after4", Full, 1);
    chk("count_after4", Count, 4);
    chk("pushack_full", PushAck, 0);
    cyc(1, 0, 0, 1);
    chk("ovf_set", OvfErr, 1);
    chk("ovf_wrptrg", WrPtrG, 3'b110);
    chk("ovf_count", Count, 4);
    PopReq = 1;
    #1;
    chk("pp_full_popack", PopAck, 1);
    chk("pp_full_pushack", PushAck, 0);
    cyc(1, 1, 0, 1);
    chk("pp_full_count", Count, 3);
    chk("pp_full_rdptrg", RdPtrG, 3'b001);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 1);
    chk("drained", Empty, 1);
    cyc(0, 0, 1, 1);
    chk("clr_ovf", OvfErr, 0);
    for (int i = 0; i < 16; i++) begin
      cyc(1, 0, 0, 1);
      cyc(0, 1, 0, 1);
    end
    cyc(1, 0, 0, 1);
    for (int i = 0; i < 20; i++) begin
      cyc(1, 1, 0, 1);
      chk("stream_count", Count, 1);
    end
    cyc(0, 1, 0, 1);
    #1;
    chk("pop_empty_popack", PopAck, 0);
    cyc(0, 1, 0, 1);
    chk("udf_set", UdfErr, 1);
    cyc(0, 0, 1, 1);
    chk("clr_udf", UdfErr, 0);
    chk("clr_wrptrg", WrPtrG, 0);
    chk("clr_rdptrg", RdPtrG, 0);
    chk("clr_empty", Empty, 1);
    cyc(1, 0, 0, 1);
    cyc(1, 0, 0, 1);
    chk("pre_rst_count", Count, 2);
    cyc(1, 0, 0, 0);
    chk("mid_rst_count", Count, 0);
    chk("mid_rst_wrptrg", WrPtrG, 0);
    chk("mid_rst_wraddr", WrAddr, 0);
    chk("mid_rst_empty", Empty, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    chk("wrap_100_000_seen", wrap_seen, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
